// File: rtl/axi4lite_slave_regs_if.sv
// AXI4-Lite bus bundle between one master and the register slave.
// Latency: none, wires only.
// Backpressure: carried by the READY/VALID pairs of each channel.
interface axi4lite_slave_regs_if #(
    parameter int ADDR_W = 32
);
    // write address channel
    logic [ADDR_W-1:0] AWADDR;
    logic [2:0]        AWPROT;
    logic              AWVALID;
    logic              AWREADY;
    // write data channel
    logic [31:0]       WDATA;
    logic [3:0]        WSTRB;
    logic              WVALID;
    logic              WREADY;
    // write response channel
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    // read address channel
    logic [ADDR_W-1:0] ARADDR;
    logic [2:0]        ARPROT;
    logic              ARVALID;
    logic              ARREADY;
    // read data channel
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit byte-writable registers, contents also driven live on REG_OUT.
// Latency: BVALID one cycle after the edge that captures the last of AW/W; RVALID one cycle after the AR handshake.
// Backpressure: B and R are held until BREADY/RREADY; while a response is pending that channel's READYs stay low.
module axi4lite_slave_regs #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 32
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    axi4lite_slave_regs_if.slave     s_axi,
    output logic [NUM_REGS*32-1:0]   REG_OUT
);
    localparam int                IDX_W       = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] SPAN        = ADDR_W'(NUM_REGS * 4);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    // register file
    logic [31:0] regs_q [NUM_REGS];

    // write path state
    wstate_t           wstate_q;
    wstate_t           wstate_d;
    logic              aw_held_q;
    logic              w_held_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              awready_q;
    logic              wready_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;

    // read path state
    rstate_t           rstate_q;
    logic              arready_q;
    logic              rvalid_q;
    logic [1:0]        rresp_q;
    logic [31:0]       rdata_q;

    // write path helpers
    logic              aw_hs;
    logic              w_hs;
    logic              aw_have;
    logic              w_have;
    logic              commit;
    logic              aw_held_d;
    logic              w_held_d;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              wr_in_range;
    logic [IDX_W-1:0]  wr_idx;

    // read path helpers
    logic              ar_hs;
    logic              rd_in_range;
    logic [IDX_W-1:0]  rd_idx;

    // protection bits carry no meaning for this block
    logic              unused_prot;
    assign unused_prot = ^{s_axi.AWPROT, s_axi.ARPROT};

    // READY is registered low outside IDLE or once held, so a handshake implies IDLE
    assign aw_hs   = s_axi.AWVALID && awready_q;
    assign w_hs    = s_axi.WVALID  && wready_q;
    assign aw_have = aw_held_q || aw_hs;
    assign w_have  = w_held_q  || w_hs;
    assign commit  = (wstate_q == W_IDLE) && aw_have && w_have;

    // the commit uses the held copy if captured earlier, else the live bus value
    assign wr_addr     = aw_held_q ? awaddr_q : s_axi.AWADDR;
    assign wr_data     = w_held_q  ? wdata_q  : s_axi.WDATA;
    assign wr_strb     = w_held_q  ? wstrb_q  : s_axi.WSTRB;
    assign wr_in_range = (wr_addr < SPAN);
    assign wr_idx      = wr_addr[IDX_W+1:2];

    assign aw_held_d = aw_have && !commit;
    assign w_held_d  = w_have  && !commit;

    assign ar_hs       = s_axi.ARVALID && arready_q;
    assign rd_in_range = (s_axi.ARADDR < SPAN);
    assign rd_idx      = s_axi.ARADDR[IDX_W+1:2];

    // next write-path state, also used to pre-compute the registered READYs
    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE:  if (commit) wstate_d = W_RESP;
            W_RESP:  if (s_axi.BREADY) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    // write FSM: capture AW/W independently, commit bytes, hold B until accepted
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_q  <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            if (aw_hs) begin
                awaddr_q <= s_axi.AWADDR;
            end
            if (w_hs) begin
                wdata_q <= s_axi.WDATA;
                wstrb_q <= s_axi.WSTRB;
            end
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= (wstate_d == W_IDLE) && !aw_held_d;
            wready_q  <= (wstate_d == W_IDLE) && !w_held_d;
            wstate_q  <= wstate_d;

            case (wstate_q)
                W_IDLE: begin
                    if (commit) begin
                        if (wr_in_range) begin
                            for (int b = 0; b < 4; b++) begin
                                if (wr_strb[b]) begin
                                    regs_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                                end
                            end
                        end
                        bvalid_q <= 1'b1;
                        bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                W_RESP: begin
                    if (s_axi.BREADY) begin
                        bvalid_q <= 1'b0;
                        bresp_q  <= RESP_OKAY;
                    end
                end
                default: begin
                    bvalid_q <= 1'b0;
                end
            endcase
        end
    end

    // read FSM: sample the register file on AR handshake, hold R until accepted
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        rdata_q   <= rd_in_range ? regs_q[rd_idx] : 32'h0;
                        rresp_q   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi.RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate_q  <= R_IDLE;
                    end
                end
                default: begin
                    rstate_q <= R_IDLE;
                end
            endcase
        end
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RRESP   = rresp_q;
    assign s_axi.RDATA   = rdata_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
        assign REG_OUT[32*k +: 32] = regs_q[k];
    end
endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed bench for axi4lite_slave_regs: stimulus pushes expected B/R responses into queues,
// a monitor pops and compares them on every B/R handshake.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_axi4lite_slave_regs;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 32;

    logic                   ACLK = 1'b0;
    logic                   ARESET = 1'b1;
    logic [NUM_REGS*32-1:0] REG_OUT;

    axi4lite_slave_regs_if #(.ADDR_W(ADDR_W)) bus ();

    axi4lite_slave_regs #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .s_axi   (bus),
        .REG_OUT (REG_OUT)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;
    int b_seen   = 0;

    logic [1:0]  exp_b_q [$];
    logic [33:0] exp_r_q [$];
    logic [1:0]  mon_b_exp;
    logic [33:0] mon_r_exp;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // scoreboard monitor
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (bus.BVALID && bus.BREADY) begin
                b_seen++;
                if (exp_b_q.size() == 0) note_fail("b_unexpected");
                else begin
                    mon_b_exp = exp_b_q.pop_front();
                    check("bresp", bus.BRESP, mon_b_exp);
                end
            end
            if (bus.RVALID && bus.RREADY) begin
                if (exp_r_q.size() == 0) note_fail("r_unexpected");
                else begin
                    mon_r_exp = exp_r_q.pop_front();
                    check("rresp_rdata", {bus.RRESP, bus.RDATA}, mon_r_exp);
                end
            end
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input logic [1:0] exp);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_fire;
        bit w_fire;
        int cyc = 0;
        exp_b_q.push_back(exp);
        while (!(aw_done && w_done) && cyc < 40) begin
            if (!aw_done && cyc == aw_dly) begin bus.AWVALID = 1'b1; bus.AWADDR = addr; end
            if (!w_done && cyc == w_dly) begin bus.WVALID = 1'b1; bus.WDATA = data; bus.WSTRB = strb; end
            @(negedge ACLK);
            aw_fire = bus.AWVALID && bus.AWREADY;
            w_fire  = bus.WVALID && bus.WREADY;
            @(posedge ACLK); #1;
            if (aw_fire) begin bus.AWVALID = 1'b0; aw_done = 1; end
            if (w_fire)  begin bus.WVALID  = 1'b0; w_done  = 1; end
            cyc++;
        end
        if (!(aw_done && w_done)) note_fail("write_handshake_timeout");
        else check("b_latency", bus.BVALID, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bit fire = 0;
        int cyc = 0;
        exp_r_q.push_back({exp_resp, exp_data});
        bus.ARVALID = 1'b1;
        bus.ARADDR  = addr;
        while (!fire && cyc < 40) begin
            @(negedge ACLK);
            fire = bus.ARVALID && bus.ARREADY;
            @(posedge ACLK); #1;
            cyc++;
        end
        bus.ARVALID = 1'b0;
        if (!fire) note_fail("read_handshake_timeout");
        else check("r_latency", bus.RVALID, 1'b1);
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge ACLK); #1;
            ok = (exp_b_q.size() == 0) && (exp_r_q.size() == 0) &&
                 bus.AWREADY && bus.WREADY && bus.ARREADY;
        end
        if (!ok) note_fail("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] snap;
        int b_before;
        bus.AWADDR = '0; bus.AWPROT = 3'b0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = 4'h0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b1;
        bus.ARADDR = '0; bus.ARPROT = 3'b0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b1;

        // reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("reset_readies", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
        check("reset_resp", {bus.BVALID, bus.BRESP, bus.RVALID, bus.RRESP, bus.RDATA}, 38'h0);
        check("reset_reg_out", REG_OUT, 256'h0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        check("ready_after_reset", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);

        // same-cycle AW+W, then read back
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00);
        wait_drain();
        check("reg1_live", REG_OUT[63:32], 32'hDEADBEEF);
        do_read(32'h04, 32'hDEADBEEF, 2'b00);
        wait_drain();

        // W leads AW by three cycles, partial strobes
        do_write(32'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b00);
        wait_drain();
        b_before = b_seen;
        do_write(32'h08, 32'h11223344, 4'b0101, 3, 0, 2'b00);
        wait_drain();
        check("one_b_pulse", b_seen - b_before, 1);
        check("reg2_live", REG_OUT[95:64], 32'hFF22FF44);
        do_read(32'h08, 32'hFF22FF44, 2'b00);
        wait_drain();

        // AW leads W by two cycles
        do_write(32'h0C, 32'hA5A5A5A5, 4'b1010, 0, 2, 2'b00);
        wait_drain();
        do_read(32'h0C, 32'hA500A500, 2'b00);
        wait_drain();

        // out of range and boundary addresses
        snap = REG_OUT;
        do_write(32'h40, 32'h12345678, 4'hF, 0, 0, 2'b10);
        wait_drain();
        check("oor_write_no_change", REG_OUT, snap);
        do_read(32'h40, 32'h0, 2'b10);
        do_read(32'h20, 32'h0, 2'b10);
        do_write(32'h1C, 32'h12345678, 4'hF, 0, 0, 2'b00);
        wait_drain();
        do_read(32'h1F, 32'h12345678, 2'b00);
        do_write(32'h04, 32'hFFFFFFFF, 4'h0, 0, 0, 2'b00);
        wait_drain();
        check("strb0_no_change", REG_OUT[63:32], 32'hDEADBEEF);

        // B backpressure
        bus.BREADY = 1'b0;
        do_write(32'h10, 32'hCAFEF00D, 4'hF, 1, 0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("b_hold", {bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY}, 5'b1_00_0_0);
        end
        @(posedge ACLK); #1;
        bus.BREADY = 1'b1;
        wait_drain();

        // R backpressure
        bus.RREADY = 1'b0;
        do_read(32'h10, 32'hCAFEF00D, 2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("r_hold", {bus.RVALID, bus.RRESP, bus.RDATA, bus.ARREADY}, {1'b1, 2'b00, 32'hCAFEF00D, 1'b0});
        end
        @(posedge ACLK); #1;
        bus.RREADY = 1'b1;
        wait_drain();

        // write commit and AR handshake on the same edge to register 1
        exp_b_q.push_back(2'b00);
        exp_r_q.push_back({2'b00, 32'hDEADBEEF});
        bus.AWVALID = 1'b1; bus.AWADDR = 32'h04;
        bus.WVALID = 1'b1; bus.WDATA = 32'h0BADC0DE; bus.WSTRB = 4'hF;
        bus.ARVALID = 1'b1; bus.ARADDR = 32'h04;
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        check("same_edge_valids", {bus.BVALID, bus.RVALID}, 2'b11);
        wait_drain();
        do_read(32'h04, 32'h0BADC0DE, 2'b00);
        wait_drain();

        // reset while both responses are pending
        bus.BREADY = 1'b0;
        bus.RREADY = 1'b0;
        do_write(32'h14, 32'h55AA55AA, 4'hF, 0, 0, 2'b00);
        do_read(32'h04, 32'h0BADC0DE, 2'b00);
        check("pre_reset_pending", {bus.BVALID, bus.RVALID}, 2'b11);
        #2;
        ARESET = 1'b1;
        exp_b_q.delete();
        exp_r_q.delete();
        #1;
        check("reset_drops_valids", {bus.BVALID, bus.RVALID, bus.AWREADY, bus.WREADY, bus.ARREADY}, 5'b0);
        check("reset_clears_regs", REG_OUT, 256'h0);
        @(posedge ACLK);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        bus.BREADY = 1'b1;
        bus.RREADY = 1'b1;
        @(posedge ACLK); #1;
        check("ready_after_rereset", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        do_read(32'h14, 32'h0, 2'b00);
        do_read(32'h04, 32'h0, 2'b00);
        wait_drain();

        check("b_queue_empty", exp_b_q.size(), 0);
        check("r_queue_empty", exp_r_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi4lite_slave_regs.md
AXI4LITE_SLAVE_REGS -- requirements
Module: axi4lite_slave_regs

Interface
REQ-001 Parameter NUM_REGS, default 8, number of 32-bit registers; legal values are powers of two from 2 to 64.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 ACLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 ARESET  input  1  reset, asynchronous, active-high.
REQ-005 AWADDR  input  ADDR_W  write address.
REQ-006 AWPROT  input  3  accepted and ignored.
REQ-007 AWVALID  input  1  write address valid.
REQ-008 AWREADY  output  1  write address ready.
REQ-009 WDATA  input  32  write data.
REQ-010 WSTRB  input  4  byte enables; bit i enables WDATA[8i+7:8i].
REQ-011 WVALID  input  1  write data valid.
REQ-012 WREADY  output  1  write data ready.
REQ-013 BRESP  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-014 BVALID  output  1  write response valid.
REQ-015 BREADY  input  1  write response ready.
REQ-016 ARADDR  input  ADDR_W  read address.
REQ-017 ARPROT  input  3  accepted and ignored.
REQ-018 ARVALID  input  1  read address valid.
REQ-019 ARREADY  output  1  read address ready.
REQ-020 RDATA  output  32  read data.
REQ-021 RRESP  output  2  read response, same encoding as BRESP.
REQ-022 RVALID  output  1  read data valid.
REQ-023 RREADY  input  1  read data ready.
REQ-024 REG_OUT  output  NUM_REGS*32  live register contents; register k maps to bits [32k+31:32k].

Function
REQ-025 Address decode: an address is in range when addr < NUM_REGS*4; register index = addr[log2(NUM_REGS)+1:2]; addr[1:0] are ignored.
REQ-026 The write path has two states: IDLE (collecting AW and W) and RESP (BVALID high).
REQ-027 AW and W are captured independently, in either order or in the same cycle. Each has a held flag.
REQ-028 AWREADY = IDLE && !aw_held; WREADY = IDLE && !w_held. Both outputs are driven from registers only.
REQ-029 On the rising edge where both AW and W are held (or the second one is captured), the block SHALL:
- write the register for each byte with WSTRB set, if the address is in range;
- clear both held flags;
- set BVALID and enter RESP.
REQ-030 BRESP = OKAY for an in-range address. For an out-of-range address, BRESP = SLVERR and no register changes.
REQ-031 WSTRB = 4'b0000 with an in-range address: no bytes change, BRESP = OKAY.
REQ-032 In RESP, BVALID and BRESP hold stable until BREADY is sampled high; the write path then returns to IDLE on that edge.
- Minimum write throughput is one write per 3 cycles.
REQ-033 The read path has two states: IDLE (ARREADY = 1) and DATA (RVALID = 1, ARREADY = 0).
REQ-034 On an AR handshake, the block SHALL register RDATA/RRESP from the register contents before that edge and enter DATA; RVALID is high the next cycle.
REQ-035 A read of an out-of-range address returns RDATA = 0 and RRESP = SLVERR.
REQ-036 In DATA, RDATA, RRESP and RVALID hold stable until RREADY is sampled high, then the read path returns to IDLE.
REQ-037 Read and write paths operate concurrently.
- If a write commits on the same edge as an AR handshake to the same register, the read returns the old value.
REQ-038 The block never deasserts BVALID or RVALID without the matching handshake, and never waits on VALID before asserting READY.

Reset
REQ-039 While ARESET is high, the following SHALL be 0: all registers, REG_OUT, the held flags, BVALID, BRESP, RVALID, RRESP, RDATA, AWREADY, WREADY and ARREADY. Both paths SHALL be in IDLE.
REQ-040 Assertion of ARESET mid-transaction discards all pending AW/W/AR and responses with no register update.
- The first rising edge after deassertion sets AWREADY, WREADY and ARREADY to 1.

Verification
REQ-041 AW 0x04 and W 0xDEADBEEF with WSTRB 4'hF in the same cycle, BREADY = 1 -> BVALID the next cycle with BRESP 00; then a read of 0x04 returns 0xDEADBEEF with RRESP 00.
REQ-042 W 0x11223344 with WSTRB 4'b0101 three cycles before AW 0x08, register 2 previously 0xFFFFFFFF -> register 2 = 0xFF22FF44, one BVALID pulse.
REQ-043 Write to 0x40 (NUM_REGS = 8) -> BRESP 10 and no register changes; read of 0x40 -> RDATA 0, RRESP 10.
REQ-044 BREADY held low for 5 cycles -> BVALID/BRESP stable for 5 cycles, AWREADY = WREADY = 0 throughout; RREADY low likewise holds RDATA stable.
REQ-045 Write to register 1 committing on the same edge as an AR handshake to 0x04 -> RDATA is the old value; a following read returns the new value.
REQ-046 ARESET pulsed while BVALID = 1 and RVALID = 1 -> both drop immediately, all registers read 0 afterwards.
